dsp_pipe_reg: RTL and testbench
===============================

DSP_PIPE_REG -- requirements
Module: dsp_pipe_reg

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, data width in bits (1..64).
REQ-002 The module SHALL have parameter DEPTH, default 2, number of register stages (1..8).
REQ-003 The module SHALL derive OCC_W = clog2(DEPTH+1), occupancy width.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port flush  input  1  synchronous discard of all pipeline contents.
REQ-007 Port in_valid  input  1  upstream data valid.
REQ-008 Port in_ready  output  1  pipeline can accept in_data this cycle.
REQ-009 Port in_data  input  WIDTH  upstream data.
REQ-010 Port out_valid  output  1  last stage holds valid data.
REQ-011 Port out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 Port out_data  output  WIDTH  last-stage data, registered, no combinational path from in_data.
REQ-013 Port occupancy  output  OCC_W  number of valid stages, registered.

Function
REQ-014 Stages SHALL be numbered 0 (input side) to DEPTH-1 (output side); each holds a valid bit v[i] and data d[i].
REQ-015 Output stage SHALL advance (empty) when out_valid and out_ready are both 1 (output handshake).
REQ-016 Stage i SHALL load from stage i-1 (stage 0 from in_data) when its source is valid and stage i is empty or advancing in the same cycle (bubble collapse).
REQ-017 in_ready SHALL equal (!v[0] or stage 0 advancing) and !flush; combinational on out_ready allowed, no path from in_valid to in_ready.
REQ-018 Input handshake SHALL occur when in_valid and in_ready are both 1; in_data is captured into d[0] at that edge.
REQ-019 A stage whose valid bit is 0 after the edge SHALL leave its data register unchanged (no load of invalid data).
REQ-020 Latency SHALL be exactly DEPTH cycles from input handshake to out_valid with out_ready held 1 and no flush.
REQ-021 Throughput SHALL be one word per cycle in steady state with in_valid=1, out_ready=1.
REQ-022 Words SHALL leave in acceptance order; none dropped or duplicated except by flush or reset.
REQ-023 When full (all v=1) and out_ready=1, an input handshake and output handshake SHALL both occur in the same cycle; occupancy stays DEPTH.
REQ-024 When full and out_ready=0, in_ready SHALL be 0 and all stages hold data and valid.
REQ-025 flush=1 SHALL clear every v[i] at the next edge regardless of in_valid/out_ready; no input accepted that cycle; an output handshake in the flush cycle still counts as delivered.
REQ-026 occupancy SHALL equal the count of v[i]=1 after each edge, range 0..DEPTH, no wrap.
REQ-027 DEPTH=1 SHALL behave as a single full-throughput register slice (REQ-023 applies).

Reset
REQ-028 On rst_n=0, asynchronously: all v[i]=0, all d[i]=0, out_valid=0, out_data=0, occupancy=0; in_ready=0 while rst_n=0.
REQ-029 Reset asserted mid-transfer SHALL discard all words; first accepted word after release is the first output.
REQ-030 First input handshake SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 WIDTH=32, DEPTH=2, out_ready=1, feed 0x00000001..0x00000005 back-to-back -> out_valid first at cycle 2 after first accept, outputs 1..5 on consecutive cycles, occupancy 2 in steady state.
REQ-032 DEPTH=2, fill with 0xA, 0xB, out_ready=0 for 4 cycles -> in_ready=0, out_data=0xA held, occupancy=2; then out_ready=1 with in_valid=1 data 0xC -> 0xA, 0xB, 0xC delivered, one per cycle.
REQ-033 DEPTH=4, single word 0x55 then idle, out_ready=1 -> out_valid one cycle at cycle 4, out_data 0x55, occupancy returns to 0.
REQ-034 DEPTH=4, out_ready=0, push 0x1, idle 2, push 0x2 -> bubbles collapse, occupancy 2, v[3]=1 and v[2]=1, order 0x1 then 0x2 on release.
REQ-035 DEPTH=3 full, flush=1 with in_valid=1 data 0x99 -> next cycle occupancy=0, out_valid=0, 0x99 never appears at output.
REQ-036 Assert rst_n=0 asynchronously between edges while full -> out_valid, occupancy, out_data go 0 immediately; after release, push 0x7 -> 0x7 is first output.

Source files
------------

// File: rtl/dsp_pipe_reg.sv
// Elastic DEPTH-stage register pipeline with bubble collapse; latency DEPTH cycles, one word/cycle.
// Backpressure: a stalled output stage holds; in_ready drops only once stage 0 cannot move forward.
module dsp_pipe_reg #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0]              v_q, v_d;
    logic [DEPTH-1:0]              adv;
    logic [DEPTH-1:0]              load;
    logic [DEPTH:0]                load_ext;
    logic [DEPTH-1:0][WIDTH-1:0]   d_q, d_d;
    logic [DEPTH:0][WIDTH-1:0]     src;
    logic [OCC_W-1:0]              occ_q, occ_d;
    logic                          in_hs;
    logic                          go;

    // Advance flags ripple from the output stage back towards stage 0.
    always_comb begin
        adv          = '0;
        go           = v_q[DEPTH-1] & out_ready;
        adv[DEPTH-1] = go;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            go     = v_q[i] & (~v_q[i+1] | go);
            adv[i] = go;
        end
    end

    assign in_ready = rst_n & ~flush & (~v_q[0] | adv[0]);
    assign in_hs    = in_valid & in_ready;

    // Stage i is fed by stage i-1; stage 0 is fed by the input port.
    assign load_ext = {adv, in_hs};
    assign load     = load_ext[DEPTH-1:0];
    assign src      = {d_q, in_data};

    always_comb begin
        v_d   = v_q;
        d_d   = d_q;
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_d[i] = ~flush & (load[i] | (v_q[i] & ~adv[i]));
            if (load[i] && !flush) begin
                d_d[i] = src[i];
            end
            occ_d = occ_d + OCC_W'(v_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            d_q   <= '0;
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// Bench driving four pipeline depths (1..4) from one shared stimulus; directed scenarios plus
// a randomized run checked against a queue-of-words position model.
module tb_dsp_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;

    logic        ir [1:4];
    logic        ov [1:4];
    logic [31:0] od [1:4];
    logic [0:0]  occ1;
    logic [1:0]  occ2;
    logic [1:0]  occ3;
    logic [2:0]  occ4;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: per depth, words in flight ordered oldest first, each with its stage position.
    logic [31:0] mw [1:4][0:4];
    int          mp [1:4][0:4];
    int          mn [1:4];

    always #5 clk = ~clk;

    dsp_pipe_reg #(.WIDTH(32), .DEPTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .occupancy(occ1));
    dsp_pipe_reg #(.WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .occupancy(occ2));
    dsp_pipe_reg #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[3]),
        .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]),
        .occupancy(occ3));
    dsp_pipe_reg #(.WIDTH(32), .DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[4]),
        .in_data(in_data), .out_valid(ov[4]), .out_ready(out_ready), .out_data(od[4]),
        .occupancy(occ4));

    function automatic logic [31:0] occ(input int k);
        case (k)
            1:       return 32'(occ1);
            2:       return 32'(occ2);
            3:       return 32'(occ3);
            default: return 32'(occ4);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #2;
        for (int k = 1; k <= 4; k++) begin
            n_tests++; if (ir[k] !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready d%0d: got %b expected 0", k, ir[k]); end
            n_tests++; if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid d%0d: got %b expected 0", k, ov[k]); end
            n_tests++; if (od[k] !== 32'h0) begin n_fail++; $display("FAIL rst_out_data d%0d: got %h expected 0", k, od[k]); end
            n_tests++; if (occ(k) !== 32'd0) begin n_fail++; $display("FAIL rst_occ d%0d: got %0d expected 0", k, occ(k)); end
        end
        rst_n   = 1'b1;
        in_data = 32'h0000_0042;
        #1;
        for (int k = 1; k <= 4; k++) begin
            n_tests++; if (ir[k] !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready d%0d: got %b expected 1", k, ir[k]); end
        end
        tick();
        for (int k = 1; k <= 4; k++) begin
            n_tests++; if (occ(k) !== 32'd1) begin n_fail++; $display("FAIL first_accept_occ d%0d: got %0d expected 1", k, occ(k)); end
        end
        n_tests++; if (ov[1] !== 1'b1 || od[1] !== 32'h42) begin n_fail++; $display("FAIL first_accept_d1: got v=%b %h expected v=1 42", ov[1], od[1]); end
    endtask

    task automatic test_back_to_back();
        int exp_occ;
        reset_dut();
        out_ready = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            in_valid = (t <= 5);
            in_data  = (t <= 5) ? 32'(t) : 32'h0;
            #1;
            if (t <= 5) begin
                n_tests++; if (ir[2] !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready d2 t=%0d: got %b expected 1", t, ir[2]); end
                n_tests++; if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready d1 t=%0d: got %b expected 1", t, ir[1]); end
            end
            tick();
            exp_occ = (t == 1) ? 1 : (t <= 5) ? 2 : (t == 6) ? 1 : 0;
            n_tests++; if (ov[2] !== (t >= 2 && t <= 6)) begin n_fail++; $display("FAIL b2b_out_valid d2 t=%0d: got %b", t, ov[2]); end
            if (t >= 2 && t <= 6) begin
                n_tests++; if (od[2] !== 32'(t - 1)) begin n_fail++; $display("FAIL b2b_out_data d2 t=%0d: got %h expected %h", t, od[2], t - 1); end
            end
            n_tests++; if (occ(2) !== 32'(exp_occ)) begin n_fail++; $display("FAIL b2b_occ d2 t=%0d: got %0d expected %0d", t, occ(2), exp_occ); end
            n_tests++; if (ov[1] !== (t <= 5)) begin n_fail++; $display("FAIL b2b_out_valid d1 t=%0d: got %b", t, ov[1]); end
            if (t <= 5) begin
                n_tests++; if (od[1] !== 32'(t)) begin n_fail++; $display("FAIL b2b_out_data d1 t=%0d: got %h expected %h", t, od[1], t); end
            end
            n_tests++; if (occ(1) !== ((t <= 5) ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL b2b_occ d1 t=%0d: got %0d", t, occ(1)); end
        end
    endtask

    task automatic test_stall();
        reset_dut();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        #1;
        n_tests++; if (ir[2] !== 1'b1) begin n_fail++; $display("FAIL stall_fill_ready: got %b expected 1", ir[2]); end
        tick();
        in_data = 32'hC;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_tests++; if (ir[2] !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c=%0d: got %b expected 0", c, ir[2]); end
            tick();
            n_tests++; if (ov[2] !== 1'b1 || od[2] !== 32'hA || occ(2) !== 32'd2)
                begin n_fail++; $display("FAIL stall_hold c=%0d: got v=%b d=%h occ=%0d expected v=1 d=a occ=2", c, ov[2], od[2], occ(2)); end
        end
        out_ready = 1'b1;
        #1;
        n_tests++; if (ir[2] !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", ir[2]); end
        tick();
        n_tests++; if (ov[2] !== 1'b1 || od[2] !== 32'hB || occ(2) !== 32'd2)
            begin n_fail++; $display("FAIL release_1: got v=%b d=%h occ=%0d expected v=1 d=b occ=2", ov[2], od[2], occ(2)); end
        in_valid = 1'b0;
        tick();
        n_tests++; if (ov[2] !== 1'b1 || od[2] !== 32'hC || occ(2) !== 32'd1)
            begin n_fail++; $display("FAIL release_2: got v=%b d=%h occ=%0d expected v=1 d=c occ=1", ov[2], od[2], occ(2)); end
        tick();
        n_tests++; if (ov[2] !== 1'b0 || occ(2) !== 32'd0)
            begin n_fail++; $display("FAIL release_3: got v=%b occ=%0d expected v=0 occ=0", ov[2], occ(2)); end
    endtask

    task automatic test_single_word();
        reset_dut();
        out_ready = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            in_valid = (t == 1);
            in_data  = (t == 1) ? 32'h55 : 32'h0;
            tick();
            n_tests++; if (ov[4] !== (t == 4)) begin n_fail++; $display("FAIL single_out_valid d4 t=%0d: got %b", t, ov[4]); end
            if (t == 4) begin
                n_tests++; if (od[4] !== 32'h55) begin n_fail++; $display("FAIL single_out_data d4: got %h expected 55", od[4]); end
            end
            n_tests++; if (occ(4) !== ((t <= 4) ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL single_occ d4 t=%0d: got %0d", t, occ(4)); end
        end
    endtask

    task automatic test_bubble_collapse();
        reset_dut();
        out_ready = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            in_valid = (t == 1 || t == 4);
            in_data  = (t == 1) ? 32'h1 : (t == 4) ? 32'h2 : 32'h0;
            tick();
            if (t == 4) begin
                n_tests++; if (ov[4] !== 1'b1 || od[4] !== 32'h1 || occ(4) !== 32'd2)
                    begin n_fail++; $display("FAIL bubble_t4: got v=%b d=%h occ=%0d expected v=1 d=1 occ=2", ov[4], od[4], occ(4)); end
            end
        end
        n_tests++; if (ov[4] !== 1'b1 || od[4] !== 32'h1 || occ(4) !== 32'd2 || ir[4] !== 1'b1)
            begin n_fail++; $display("FAIL bubble_settled: got v=%b d=%h occ=%0d rdy=%b expected v=1 d=1 occ=2 rdy=1", ov[4], od[4], occ(4), ir[4]); end
        out_ready = 1'b1;
        tick();
        n_tests++; if (ov[4] !== 1'b1 || od[4] !== 32'h2 || occ(4) !== 32'd1)
            begin n_fail++; $display("FAIL bubble_release_1: got v=%b d=%h occ=%0d expected v=1 d=2 occ=1", ov[4], od[4], occ(4)); end
        tick();
        n_tests++; if (ov[4] !== 1'b0 || occ(4) !== 32'd0)
            begin n_fail++; $display("FAIL bubble_release_2: got v=%b occ=%0d expected v=0 occ=0", ov[4], occ(4)); end
    endtask

    task automatic test_flush();
        reset_dut();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            in_data = 32'(t * 32'h11);
            tick();
        end
        n_tests++; if (occ(3) !== 32'd3) begin n_fail++; $display("FAIL flush_full_occ: got %0d expected 3", occ(3)); end
        flush     = 1'b1;
        in_data   = 32'h99;
        out_ready = 1'b1;
        #1;
        n_tests++; if (ir[3] !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", ir[3]); end
        n_tests++; if (ov[3] !== 1'b1 || od[3] !== 32'h11) begin n_fail++; $display("FAIL flush_delivered: got v=%b d=%h expected v=1 d=11", ov[3], od[3]); end
        tick();
        n_tests++; if (ov[3] !== 1'b0 || occ(3) !== 32'd0) begin n_fail++; $display("FAIL flush_clear: got v=%b occ=%0d expected v=0 occ=0", ov[3], occ(3)); end
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++; if (ov[3] !== 1'b0 || od[3] !== 32'h11)
                begin n_fail++; $display("FAIL flush_after c=%0d: got v=%b d=%h expected v=0 d=11", c, ov[3], od[3]); end
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h31;
        tick();
        in_data = 32'h32;
        tick();
        in_valid = 1'b0;
        n_tests++; if (occ(2) !== 32'd2) begin n_fail++; $display("FAIL areset_full: got %0d expected 2", occ(2)); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (ov[2] !== 1'b0 || occ(2) !== 32'd0 || od[2] !== 32'h0 || ir[2] !== 1'b0)
            begin n_fail++; $display("FAIL areset_immediate: got v=%b occ=%0d d=%h rdy=%b expected all 0", ov[2], occ(2), od[2], ir[2]); end
        #3;
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h7;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_tests++; if (ov[2] !== 1'b1 || od[2] !== 32'h7) begin n_fail++; $display("FAIL areset_first_out: got v=%b d=%h expected v=1 d=7", ov[2], od[2]); end
    endtask

    task automatic test_random();
        logic [31:0] tw [0:4];
        int          tp [0:4];
        int          n, lim, np, first;
        logic        exp_ov, pop, exp_ir;
        reset_dut();
        for (int k = 1; k <= 4; k++) mn[k] = 0;
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = $urandom;
            #1;
            for (int k = 1; k <= 4; k++) begin
                exp_ov = (mn[k] > 0) && (mp[k][0] == k - 1);
                pop    = exp_ov && out_ready;
                first  = pop ? 1 : 0;
                n      = 0;
                lim    = k - 1;
                // Every remaining word moves one stage forward unless blocked by the word ahead.
                for (int j = first; j < mn[k]; j++) begin
                    np = mp[k][j] + 1;
                    if (np > lim) np = lim;
                    tw[n] = mw[k][j];
                    tp[n] = np;
                    lim   = np - 1;
                    n++;
                end
                exp_ir = !flush && (n == 0 || tp[n-1] > 0);
                n_tests++; if (ir[k] !== exp_ir) begin n_fail++; $display("FAIL rand_in_ready d%0d c=%0d: got %b expected %b", k, c, ir[k], exp_ir); end
                if (flush) begin
                    n = 0;
                end else if (in_valid && exp_ir) begin
                    tw[n] = in_data;
                    tp[n] = 0;
                    n++;
                end
                for (int j = 0; j < n; j++) begin
                    mw[k][j] = tw[j];
                    mp[k][j] = tp[j];
                end
                mn[k] = n;
            end
            tick();
            for (int k = 1; k <= 4; k++) begin
                exp_ov = (mn[k] > 0) && (mp[k][0] == k - 1);
                n_tests++; if (ov[k] !== exp_ov) begin n_fail++; $display("FAIL rand_out_valid d%0d c=%0d: got %b expected %b", k, c, ov[k], exp_ov); end
                if (exp_ov) begin
                    n_tests++; if (od[k] !== mw[k][0]) begin n_fail++; $display("FAIL rand_out_data d%0d c=%0d: got %h expected %h", k, c, od[k], mw[k][0]); end
                end
                n_tests++; if (occ(k) !== 32'(mn[k])) begin n_fail++; $display("FAIL rand_occ d%0d c=%0d: got %0d expected %0d", k, c, occ(k), mn[k]); end
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_single_word();
        test_bubble_collapse();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
